mdio_peripheral: RTL and testbench
==================================

# mdio_peripheral

PHY-side MDIO management slave that sits directly downstream of the MDIO controller. It decodes the controller's serial frames (`mdc`, `mdio_out`, `mdio_oe`) and turns them into single-cycle register-file accesses. For read frames it drives the returned data back to the controller on `mdio_in`. The register file itself is external; this block only owns the serial protocol and the strobes.

## Interface
- `PHY_ADDR`, default 5'h1F: PHY address this block answers to.
- `clk`  in  1  system clock; `mdc` is generated from it by the controller.
- `reset`  in  1  asynchronous, active-low reset.
- `mdc`  in  1  management clock from the controller.
- `mdio_out`  in  1  serial data from the controller.
- `mdio_oe`  in  1  controller output enable; high while the controller drives the bus.
- `reg_rd_data`  in  16  read data from the register file, valid the clk after `rd_stb`.
- `mdio_in`  out  1  serial data to the controller.
- `mdio_in_oe`  out  1  high while this block drives `mdio_in`.
- `reg_addr`  out  5  register address (REGAD field), held until the next frame header.
- `wr_data`  out  16  write data.
- `wr_stb`  out  1  one-clk write strobe.
- `rd_stb`  out  1  one-clk read strobe.

## Operation
- **Frame format:** 32 bits, MSB first, no preamble.
  - ST[1:0] = 01.
  - OP[1:0]: 01 = write, 10 = read.
  - PHYAD[4:0], REGAD[4:0], TA[1:0], DATA[15:0].
  - Bit index k runs 0..31.
- **Edge detection:** `mdc_q` is `mdc` registered, reset 0.
  - Rise = `mdc & ~mdc_q`.
  - Fall = `~mdc & mdc_q`.
  - All protocol actions happen on the clk edge where rise or fall is detected.
- **Sampling:** `mdio_out` is sampled on rise. Bit k is captured on the k-th rise of the frame.
- **State machine:** IDLE, HEADER, WDATA, RTA, RDATA, SKIP. A 5-bit `bit_cnt` tracks the bit index.
- **IDLE:**
  - A rise with `mdio_oe`=1 is bit 0.
  - Go to HEADER with `bit_cnt`=1.
- **HEADER (bits 0..13):** shift in ST, OP, PHYAD, REGAD.
  - A rise with `mdio_oe`=0 aborts to IDLE.
  - After bit 1: if ST≠01, go to SKIP.
  - After bit 13:
    - PHYAD≠`PHY_ADDR`, or OP ∈ {00, 11}: go to SKIP.
    - OP=01: go to WDATA.
    - OP=10: latch `reg_addr`, pulse `rd_stb`, go to RTA.
- **WDATA (bits 14..31):** TA bits are shifted but ignored.
  - A rise with `mdio_oe`=0 aborts to IDLE with no strobe.
  - On the rise sampling bit 31: latch `reg_addr` and `wr_data`, pulse `wr_stb` on the next clk, return to IDLE.
- **RTA:** capture `reg_rd_data` into a 16-bit shift register on the clk after `rd_stb`.
  - Bit 14 (controller TA, Z) is not driven.
  - On the fall after rise 14: `mdio_in_oe`=1, `mdio_in`=0 (TA bit 15). Go to RDATA.
- **RDATA:** on each fall after rise k (k=15..30), drive `mdio_in` = DATA bit (30−k), i.e. bits 15..0 in order.
  - On the fall after rise 31: `mdio_in_oe`=0, `mdio_in`=0, go to IDLE.
  - `mdio_oe` is ignored in this state.
- **SKIP:** drive nothing, produce no strobes.
  - Counts rises to bit 31, then returns to IDLE.
  - Returns to IDLE earlier if a rise sees `mdio_oe`=0.
- **Reset values:** `mdio_in`=0, `mdio_in_oe`=0, `reg_addr`=0, `wr_data`=0, `wr_stb`=0, `rd_stb`=0; state IDLE, `bit_cnt`=0, `mdc_q`=0.

## Timing
- **Strobes:** `wr_stb` and `rd_stb` are high for exactly one clk and never high together.
- **Write latency:** `wr_stb` rises one clk after the clk that detected rise 31.
- **Read latency:** `rd_stb` rises one clk after the clk that detected rise 13. `reg_rd_data` is sampled on the following clk. The minimum MDC half-period is 2 clk, so data is captured before fall 14.
- **Read drive:** `mdio_in` changes only on fall-detect clks, so it is stable across every controller rise. `mdio_in_oe` is high from fall 14 through fall 31 inclusive: 17 MDC periods.
- **Back-to-back:** a new frame may start on the first rise after the completing edge (rise 31 for write, fall 31 for read).
- **Reset mid-frame:** asserting `reset` forces reset values immediately. This includes releasing `mdio_in_oe` and cancelling any pending strobe. No partial write is ever issued.
- **MDC idle:** if `mdc` stops mid-frame, all state holds. There is no timeout.

## Test plan
- **Write:** frame 01 01 11111 10010 10 0x28DB with `PHY_ADDR`=5'h1F -> exactly one `wr_stb`, `reg_addr`=5'h12, `wr_data`=16'h28DB; `mdio_in_oe` stays 0.
- **Read:** frame header 01 10 11111 10010, `reg_rd_data`=16'h0EC6 -> one `rd_stb` with `reg_addr`=5'h12; `mdio_in` at rises 15..31 = 0, 0000111011000110; `mdio_in_oe` high fall 14..fall 31.
- **PHY mismatch:** write frame with PHYAD 5'h03 -> no strobes, `mdio_in_oe`=0 throughout; the next valid frame is decoded normally.
- **Bad ST/OP:** ST=11 in one frame, then OP=00 in another -> SKIP, no strobes; an immediately following valid read returns correct data.
- **Abort and reset:** `mdio_oe` dropped at bit 20 of a write -> no `wr_stb`, back to IDLE. `reset`=0 asserted at bit 24 of a read -> `mdio_in_oe`=0 and all outputs at reset values within the same time step.
- **Back-to-back:** write 0x1234 to reg 5'h01, then immediately read reg 5'h01 with the model returning 0x1234 -> serial data 0x1234.

Source files
------------

// File: rtl/mdio_peripheral.sv
// PHY-side MDIO slave: decodes 32-bit controller frames (no preamble) into
// single-cycle register-file strobes and serialises read data back on mdio_in.
module mdio_peripheral #(
  parameter logic [4:0] PHY_ADDR = 5'h1F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_out,
  input  logic        mdio_oe,
  input  logic [15:0] reg_rd_data,
  output logic        mdio_in,
  output logic        mdio_in_oe,
  output logic [4:0]  reg_addr,
  output logic [15:0] wr_data,
  output logic        wr_stb,
  output logic        rd_stb
);

  typedef enum logic [2:0] {IDLE, HEADER, WDATA, RTA, RDATA, SKIP} state_t;

  state_t      state_q, state_d;
  logic        mdc_q;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] sh_q, sh_d;
  logic [4:0]  regad_q, regad_d;
  logic [15:0] rd_sh_q, rd_sh_d;
  logic        rd_cap_q;
  logic [4:0]  reg_addr_d;
  logic [15:0] wr_data_d;
  logic        wr_stb_d, rd_stb_d, mdio_in_d, mdio_in_oe_d;

  logic        rise, fall;
  logic [15:0] sh_next;
  logic [4:0]  cnt_inc;

  assign rise    = mdc & ~mdc_q;
  assign fall    = ~mdc & mdc_q;
  assign sh_next = {sh_q[14:0], mdio_out};
  assign cnt_inc = bit_cnt_q + 5'd1;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    sh_d         = sh_q;
    regad_d      = regad_q;
    rd_sh_d      = rd_sh_q;
    reg_addr_d   = reg_addr;
    wr_data_d    = wr_data;
    wr_stb_d     = 1'b0;
    rd_stb_d     = 1'b0;
    mdio_in_d    = mdio_in;
    mdio_in_oe_d = mdio_in_oe;

    // Register file answers the clk after rd_stb; grab it then.
    if (rd_cap_q) rd_sh_d = reg_rd_data;

    case (state_q)
      IDLE: begin
        if (rise && mdio_oe) begin
          sh_d      = sh_next;
          bit_cnt_d = 5'd1;
          state_d   = HEADER;
        end
      end
      HEADER: begin
        if (rise) begin
          if (!mdio_oe) begin
            state_d   = IDLE;
            bit_cnt_d = 5'd0;
          end else begin
            sh_d      = sh_next;
            bit_cnt_d = cnt_inc;
            if (bit_cnt_q == 5'd1 && sh_next[1:0] != 2'b01) begin
              state_d = SKIP;
            end else if (bit_cnt_q == 5'd13) begin
              // sh_next[13:0] = {ST, OP, PHYAD, REGAD}
              regad_d = sh_next[4:0];
              if (sh_next[9:5] != PHY_ADDR) begin
                state_d = SKIP;
              end else if (sh_next[11:10] == 2'b01) begin
                state_d = WDATA;
              end else if (sh_next[11:10] == 2'b10) begin
                reg_addr_d = sh_next[4:0];
                rd_stb_d   = 1'b1;
                state_d    = RTA;
              end else begin
                state_d = SKIP;
              end
            end
          end
        end
      end
      WDATA: begin
        if (rise) begin
          if (!mdio_oe) begin
            state_d   = IDLE;
            bit_cnt_d = 5'd0;
          end else if (bit_cnt_q == 5'd31) begin
            sh_d       = sh_next;
            reg_addr_d = regad_q;
            wr_data_d  = sh_next;
            wr_stb_d   = 1'b1;
            state_d    = IDLE;
            bit_cnt_d  = 5'd0;
          end else begin
            sh_d      = sh_next;
            bit_cnt_d = cnt_inc;
          end
        end
      end
      RTA: begin
        if (rise) begin
          bit_cnt_d = cnt_inc;
        end else if (fall && bit_cnt_q == 5'd15) begin
          mdio_in_oe_d = 1'b1;
          mdio_in_d    = 1'b0;
          state_d      = RDATA;
        end
      end
      RDATA: begin
        // bit_cnt already points one past the last rise, wrapping to 0 after rise 31.
        if (rise) begin
          bit_cnt_d = cnt_inc;
        end else if (fall) begin
          if (bit_cnt_q == 5'd0) begin
            mdio_in_oe_d = 1'b0;
            mdio_in_d    = 1'b0;
            state_d      = IDLE;
          end else if (bit_cnt_q >= 5'd16) begin
            mdio_in_d = rd_sh_q[15];
            rd_sh_d   = {rd_sh_q[14:0], 1'b0};
          end
        end
      end
      SKIP: begin
        if (rise) begin
          if (!mdio_oe || bit_cnt_q == 5'd31) begin
            state_d   = IDLE;
            bit_cnt_d = 5'd0;
          end else begin
            bit_cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mdc_q      <= 1'b0;
      bit_cnt_q  <= 5'd0;
      sh_q       <= 16'd0;
      regad_q    <= 5'd0;
      rd_sh_q    <= 16'd0;
      rd_cap_q   <= 1'b0;
      reg_addr   <= 5'd0;
      wr_data    <= 16'd0;
      wr_stb     <= 1'b0;
      rd_stb     <= 1'b0;
      mdio_in    <= 1'b0;
      mdio_in_oe <= 1'b0;
    end else begin
      state_q    <= state_d;
      mdc_q      <= mdc;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      regad_q    <= regad_d;
      rd_sh_q    <= rd_sh_d;
      rd_cap_q   <= rd_stb;
      reg_addr   <= reg_addr_d;
      wr_data    <= wr_data_d;
      wr_stb     <= wr_stb_d;
      rd_stb     <= rd_stb_d;
      mdio_in    <= mdio_in_d;
      mdio_in_oe <= mdio_in_oe_d;
    end
  end

endmodule

// File: tb/tb_mdio_peripheral.sv
// Scoreboard bench for mdio_peripheral: a controller model drives frames, a
// small register file answers strobes, and expected strobes/read words are queued.
module tb_mdio_peripheral;

  localparam int H = 3;  // MDC half-period in clk cycles

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mdc = 1'b0;
  logic        mdio_out = 1'b0;
  logic        mdio_oe = 1'b0;
  logic [15:0] reg_rd_data = 16'h0;
  logic        mdio_in, mdio_in_oe, wr_stb, rd_stb;
  logic [4:0]  reg_addr;
  logic [15:0] wr_data;

  always #5 clk = ~clk;

  mdio_peripheral #(.PHY_ADDR(5'h1F)) dut (
    .clk(clk), .reset(reset), .mdc(mdc), .mdio_out(mdio_out), .mdio_oe(mdio_oe),
    .reg_rd_data(reg_rd_data), .mdio_in(mdio_in), .mdio_in_oe(mdio_in_oe),
    .reg_addr(reg_addr), .wr_data(wr_data), .wr_stb(wr_stb), .rd_stb(rd_stb)
  );

  typedef struct packed {
    logic        is_wr;
    logic [4:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] rd_exp[$];
  int          total = 0;
  int          bad = 0;

  // Register file: answers rd_stb one clk later.
  logic [15:0] mem [32];
  logic        poke_en = 1'b0;
  logic [4:0]  poke_a = 5'd0;
  logic [15:0] poke_d = 16'd0;

  always @(posedge clk) begin
    if (poke_en) mem[poke_a] <= poke_d;
    if (wr_stb) mem[reg_addr] <= wr_data;
    if (rd_stb) reg_rd_data <= mem[reg_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, expv);
    end
  endtask

  // Strobe monitor
  logic prev_stb = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset && (wr_stb || rd_stb)) begin
      chk("stb_both", 32'(wr_stb & rd_stb), 32'd0);
      chk("stb_width", 32'(prev_stb), 32'd0);
      chk("stb_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stb_kind", 32'(wr_stb), 32'(e.is_wr));
        chk("stb_addr", 32'(reg_addr), 32'(e.addr));
        if (wr_stb) chk("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
    prev_stb <= wr_stb | rd_stb;
  end

  task automatic poke(input logic [4:0] a, input logic [15:0] d);
    poke_a = a; poke_d = d; poke_en = 1'b1;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic mdc_bit(input logic oe, input logic d, output logic s_in, output logic s_oe);
    mdio_oe = oe;
    mdio_out = d;
    repeat (H) @(negedge clk);
    mdc = 1'b1;
    s_in = mdio_in;
    s_oe = mdio_in_oe;
    repeat (H) @(negedge clk);
    mdc = 1'b0;
  endtask

  // drop_at: bit where the controller drops mdio_oe and gives up.
  // stop_at: bit before which the frame simply stops (mdc parked low).
  task automatic send(input logic [1:0] st, input logic [1:0] op, input logic [4:0] phy,
                      input logic [4:0] ra, input logic [15:0] data,
                      input int drop_at, input int stop_at);
    logic [31:0] bits;
    logic        is_rd, resp, oe, s, so;
    logic [16:0] word;
    bits  = {st, op, phy, ra, 2'b10, data};
    is_rd = (op == 2'b10);
    resp  = is_rd && (st == 2'b01) && (phy == 5'h1F);
    word  = 17'd0;
    for (int k = 0; k < 32; k++) begin
      if (k == stop_at) return;
      oe = !(is_rd && k >= 14) && (k != drop_at);
      mdc_bit(oe, oe ? bits[31-k] : 1'b0, s, so);
      chk($sformatf("in_oe_r%0d", k), 32'(so), 32'(resp && k >= 15));
      if (resp && k >= 15) word = {word[15:0], s};
      if (k == drop_at) return;
    end
    if (resp) chk("rdata", 32'(word), {15'd0, 1'b0, rd_exp.pop_front()});
    mdio_oe = 1'b0;
    repeat (H) @(negedge clk);
    chk("in_oe_end", 32'(mdio_in_oe), 32'd0);
    chk("in_end", 32'(mdio_in), 32'd0);
  endtask

  task automatic do_wr(input logic [4:0] ra, input logic [15:0] d);
    exp_q.push_back('{is_wr: 1'b1, addr: ra, data: d});
    send(2'b01, 2'b01, 5'h1F, ra, d, -1, -1);
  endtask

  task automatic do_rd(input logic [4:0] ra, input logic [15:0] expd);
    exp_q.push_back('{is_wr: 1'b0, addr: ra, data: 16'h0});
    rd_exp.push_back(expd);
    send(2'b01, 2'b10, 5'h1F, ra, 16'h0, -1, -1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mdio_in", 32'(mdio_in), 32'd0);
    chk("rst_in_oe", 32'(mdio_in_oe), 32'd0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_wr_stb", 32'(wr_stb), 32'd0);
    chk("rst_rd_stb", 32'(rd_stb), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Read returning 0x0EC6, then the write frame 0x28DB to reg 0x12
    poke(5'h12, 16'h0EC6);
    do_rd(5'h12, 16'h0EC6);
    do_wr(5'h12, 16'h28DB);
    chk("hold_reg_addr", 32'(reg_addr), 32'h12);
    chk("hold_wr_data", 32'(wr_data), 32'h28DB);

    // PHY address mismatch, then a normal write
    send(2'b01, 2'b01, 5'h03, 5'h05, 16'hBEEF, -1, -1);
    do_wr(5'h05, 16'hA5A5);

    // Bad ST, bad OP, then an immediate valid read
    send(2'b11, 2'b01, 5'h1F, 5'h05, 16'h0000, -1, -1);
    send(2'b01, 2'b00, 5'h1F, 5'h05, 16'h0000, -1, -1);
    do_rd(5'h05, 16'hA5A5);

    // Controller abandons a write at bit 20
    send(2'b01, 2'b01, 5'h1F, 5'h07, 16'hFFFF, 20, -1);
    do_wr(5'h08, 16'h0F0F);
    do_rd(5'h08, 16'h0F0F);

    // Reset asserted at bit 24 of a read while the slave is driving
    exp_q.push_back('{is_wr: 1'b0, addr: 5'h12, data: 16'h0});
    send(2'b01, 2'b10, 5'h1F, 5'h12, 16'h0, -1, 24);
    @(negedge clk);
    chk("oe_before_rst", 32'(mdio_in_oe), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_in_oe", 32'(mdio_in_oe), 32'd0);
    chk("mid_rst_mdio_in", 32'(mdio_in), 32'd0);
    chk("mid_rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
    chk("mid_rst_wr_stb", 32'(wr_stb), 32'd0);
    chk("mid_rst_rd_stb", 32'(rd_stb), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Back-to-back write then read of the same register
    do_wr(5'h01, 16'h1234);
    do_rd(5'h01, 16'h1234);

    repeat (10) @(negedge clk);
    chk("strobes_left", 32'(exp_q.size()), 32'd0);
    chk("reads_left", 32'(rd_exp.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
